loop_fault_debounce: RTL
========================

# loop_fault_debounce

Four-channel fault qualifier for the LOOP/CONTROL section. It sits directly upstream of the generated `nor4` cell. It synchronizes and debounces four raw fault inputs and holds each qualified fault as a flag. Its `f0`..`f3` outputs drive the `nor4` inputs `i0`..`i3`, so the `nor4` output means "loop healthy".

## Interface
Parameters:
- `DB_CYCLES`, default 8: number of consecutive synchronized-high cycles needed to trip a channel. Legal range is 1..255.
- `CNT_W`, default 8: debounce counter width. Must satisfy `2**CNT_W > DB_CYCLES`.

Ports:
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `CELV`, input, 1: supply pin; passed through structurally, no functional effect.
- `CELG`, input, 1: ground pin; passed through structurally, no functional effect.
- `SUB`, input, 1: substrate pin; passed through structurally, no functional effect.
- `flt_raw`, input, 4: asynchronous raw fault inputs, active-high.
- `mask`, input, 4: per-channel disable, synchronous to `clk`.
- `clr`, input, 1: one-cycle pulse requesting that tripped flags be cleared.
- `f0`, `f1`, `f2`, `f3`, output, 1 each: qualified fault flags, feeding `nor4` `i0`..`i3`.
- `flt_any`, output, 1: registered OR of `f0`..`f3`.
- `clr_ack`, output, 1: one-cycle pulse, issued one cycle after `clr` is sampled.

## Operation
- Each channel passes its raw input through a 2-flop synchronizer (`s1` then `s2`), then through a 3-state FSM with states IDLE, QUAL and TRIP.
- **IDLE**
  - Counter is 0 and the flag is 0.
  - `s2`=1 moves the channel to QUAL with the counter set to 1.
- **QUAL**
  - The counter increments while `s2`=1.
  - `s2`=0 returns to IDLE and zeroes the counter. Any glitch shorter than `DB_CYCLES` therefore leaves no trace.
  - When the counter reaches `DB_CYCLES` while `s2`=1, the channel moves to TRIP.
  - With `DB_CYCLES`=1, the channel goes from IDLE directly to TRIP.
- **TRIP**
  - Flag is 1.
  - Exit depends on the configuration macro (see Configuration).
  - A clear is accepted only if `s2`=0 in the cycle `clr` is sampled. If `s2`=1, the clear is rejected for that channel and it stays in TRIP.
- **Mask**
  - `mask[n]`=1 forces channel n to IDLE on the next edge: counter 0, flag 0.
  - Mask overrides every other event.
- **Clear behaviour**
  - `clr` affects only channels in TRIP. Channels in QUAL keep counting.
  - `clr_ack` pulses even when every channel rejects the clear.
  - `clr` held high for several cycles produces one ack per sampled cycle.
- `flt_any` is `|{f3,f2,f1,f0}` registered one cycle after the flags.
- **Reset**
  - Synchronizers, FSMs and counters go to 0/IDLE.
  - `f0`..`f3`, `flt_any` and `clr_ack` are all 0.
  - Reset asserted mid-qualification discards the partial count.

## Timing
- **Trip latency**
  - `flt_raw[n]` is first sampled high at edge E0.
  - `s2` goes high at E1 and the channel enters QUAL.
  - The flag rises at edge E1+`DB_CYCLES`. This assumes the raw input stays high and the channel is unmasked.
- Clear: `clr` sampled at edge C. The flag falls at C, and `clr_ack` is high during the cycle after C.
- `flt_any` lags the flags by one cycle.
- Mask: asserting `mask` at edge M clears the flag at M, with no other latency.
- No combinational path exists from any input to any output.

## Configuration
- Macro: `LOOP_FAULT_STICKY_EN`.
- **Defined:** TRIP is sticky. It leaves only via `clr` (with `s2`=0), `mask`, or `rst`.
- **Undefined:**
  - TRIP also releases automatically once `s2` has been 0 for `DB_CYCLES` consecutive cycles. The counter is reused as the release counter.
  - `clr` still works as described.
  - `clr_ack` behaviour is unchanged.

## Structure
- Shared package `loop_fault_pkg` contains:
  - the channel state enum `{IDLE, QUAL, TRIP}`;
  - the constant `LOOP_FAULT_NCH` = 4.
- One sub-module, `loop_fault_chan`, holds the synchronizer, FSM and counter for a single channel. It is instantiated 4 times.
- The top level contains the `clr_ack` register, the `flt_any` register, the flag fan-out to `f0`..`f3`, and the supply-pin pass-through.

## Test plan
- **Reset:** hold `rst` for 3 cycles with `flt_raw`=4'hF. Expect all outputs 0 throughout reset and FSMs in IDLE. After release, `f0`..`f3` rise 9 cycles after the first sample (`DB_CYCLES`=8).
- **Glitch rejection:** pulse `flt_raw[1]` high for 7 cycles, low for 1, then high for 7. Expect `f1` to stay 0 and the counter to return to 0 after the low cycle.
- **Sticky clear rejection:** trip `f2`, then pulse `clr` with `flt_raw[2]` still high. Expect `f2` to stay 1 and `clr_ack`=1 on the next cycle. Drop the raw input, wait 3 cycles, then pulse `clr`. Expect `f2` to fall at the clear edge.
- **Mask override:** trip `f3` and set `mask[3]` in the same cycle as a `clr`. Expect `f3`=0 on the next edge, `clr_ack` to pulse, and `flt_any` to fall one cycle after `f3`.
- **Non-sticky build** (macro undefined): trip `f0`, then drop `flt_raw[0]`. Expect `f0` to fall 8 cycles after `s2` goes low. A 7-cycle low followed by a high keeps `f0`=1.
- **Simultaneous events:** pulse `clr` while ch0 is in TRIP (raw low) and ch1 is in QUAL (counter 5). Expect `f0` to clear, ch1 to continue, and `f1` to rise 3 edges later.

Source files
------------

// File: rtl/loop_fault_pkg.sv
`default_nettype none
// ============================================================================
// Module      : loop_fault_pkg
// Description : Shared channel-state type and channel count for the loop
//               fault qualifier.
// Revision    : 1.0 - initial release
// ============================================================================
package loop_fault_pkg;

    localparam int LOOP_FAULT_NCH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        QUAL = 2'd1,
        TRIP = 2'd2
    } chan_state_e;

endpackage
`default_nettype wire

// File: rtl/loop_fault_chan.sv
`default_nettype none
// ============================================================================
// Module      : loop_fault_chan
// Description : One fault channel: 2-flop synchronizer, IDLE/QUAL/TRIP
//               debounce FSM and counter. LOOP_FAULT_STICKY_EN makes TRIP sticky.
// Revision    : 1.0 - initial release
// ============================================================================
module loop_fault_chan
    import loop_fault_pkg::*;
#(
    parameter int DB_CYCLES = 8,
    parameter int CNT_W     = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic mask,
    input  logic clr,
    output logic flag
);

    localparam logic [CNT_W-1:0] c_DB_LAST     = CNT_W'(DB_CYCLES - 1);
    localparam bit               c_DIRECT_TRIP = (DB_CYCLES == 1);

    logic             r_s1;
    logic             r_s2;
    chan_state_e      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_flag;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_state <= IDLE;
            r_cnt   <= '0;
            r_flag  <= 1'b0;
        end else begin
            r_s1 <= raw;
            r_s2 <= r_s1;
            if (mask) begin
                r_state <= IDLE;
                r_cnt   <= '0;
                r_flag  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (r_s2) begin
                            if (c_DIRECT_TRIP) begin
                                r_state <= TRIP;
                                r_cnt   <= '0;
                                r_flag  <= 1'b1;
                            end else begin
                                r_state <= QUAL;
                                r_cnt   <= CNT_W'(1);
                            end
                        end
                    end
                    QUAL: begin
                        if (!r_s2) begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                        end else if (r_cnt == c_DB_LAST) begin
                            // Counter enters TRIP at zero, ready to time the release
                            r_state <= TRIP;
                            r_cnt   <= '0;
                            r_flag  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    TRIP: begin
                        if (clr && !r_s2) begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                            r_flag  <= 1'b0;
                        end
`ifdef LOOP_FAULT_STICKY_EN
                        else begin
                            r_flag <= 1'b1;
                        end
`else
                        else if (r_s2) begin
                            r_cnt <= '0;
                        end else if (r_cnt == c_DB_LAST) begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                            r_flag  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
`endif
                    end
                    default: begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_flag  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign flag = r_flag;

endmodule
`default_nettype wire

// File: rtl/loop_fault_debounce.sv
`default_nettype none
// ============================================================================
// Module      : loop_fault_debounce
// Description : Four-channel fault qualifier feeding nor4 i0..i3; adds the
//               flt_any and clr_ack registers. Option: LOOP_FAULT_STICKY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module loop_fault_debounce
    import loop_fault_pkg::*;
#(
    parameter int DB_CYCLES = 8,
    parameter int CNT_W     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      CELV,
    input  logic                      CELG,
    input  logic                      SUB,
    input  logic [LOOP_FAULT_NCH-1:0] flt_raw,
    input  logic [LOOP_FAULT_NCH-1:0] mask,
    input  logic                      clr,
    output logic                      f0,
    output logic                      f1,
    output logic                      f2,
    output logic                      f3,
    output logic                      flt_any,
    output logic                      clr_ack
);

    logic [LOOP_FAULT_NCH-1:0] w_flag;
    logic                      r_flt_any;
    logic                      r_clr_ack;
    logic                      w_unused_supply;

    // Supply pins only exist for the netlist; they carry no logic function
    assign w_unused_supply = &{CELV, CELG, SUB};

    generate
        for (genvar n = 0; n < LOOP_FAULT_NCH; n++) begin : g_chan
            loop_fault_chan #(
                .DB_CYCLES (DB_CYCLES),
                .CNT_W     (CNT_W)
            ) u_chan (
                .clk  (clk),
                .rst  (rst),
                .raw  (flt_raw[n]),
                .mask (mask[n]),
                .clr  (clr),
                .flag (w_flag[n])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flt_any <= 1'b0;
            r_clr_ack <= 1'b0;
        end else begin
            r_flt_any <= |w_flag;
            r_clr_ack <= clr;
        end
    end

    assign f0      = w_flag[0];
    assign f1      = w_flag[1];
    assign f2      = w_flag[2];
    assign f3      = w_flag[3];
    assign flt_any = r_flt_any;
    assign clr_ack = r_clr_ack;

endmodule
`default_nettype wire
